encrypter_in: RTL and testbench

Receive-side word assembler for the RSA datapath. It collects four consecutive UART receiver bytes, MSB first, into one 32-bit word and presents it to the crypter with a single-cycle `word_ready` pulse. It is the mirror of the transmit-side word serializer: it holds a completed word while the crypter is busy, drops bytes that arrive during that hold, and discards a partial word after an inter-byte timeout.

---
 rtl/encrypter_in.sv | 136 +++++++++++++
 tb/tb_encrypter_in.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/encrypter_in.sv
// Receive-side word assembler: packs four UART bytes (MSB first) into a 32-bit word
// for the crypter, holding the word while the crypter is busy and dropping stale partial words.
module encrypter_in #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_done_tick,
    input  logic [7:0]  rx_data,
    input  logic        crypt_busy,
    output logic        word_ready,
    output logic [31:0] data_out,
    output logic        receiving,
    output logic        overrun_tick,
    output logic        timeout_tick
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    // The timer is checked before it increments, so the expiry compare uses TIMEOUT_CYCLES-2.
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [1:0]    byte_count;
    logic [1:0]    byte_count_next;
    logic [31:0]   shift_buf;
    logic [31:0]   shift_buf_next;
    logic [31:0]   shifted;
    logic [31:0]   data_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic          ready_next;
    logic          overrun_next;
    logic          timeout_next;

    assign shifted   = {shift_buf[23:0], rx_data};
    assign receiving = (state != IDLE);

    always_comb begin
        state_next      = state;
        byte_count_next = byte_count;
        shift_buf_next  = shift_buf;
        timer_next      = timer;
        data_next       = data_out;
        ready_next      = 1'b0;
        overrun_next    = 1'b0;
        timeout_next    = 1'b0;

        case (state)
            IDLE: begin
                if (rx_done_tick) begin
                    shift_buf_next  = shifted;
                    byte_count_next = 2'd1;
                    timer_next      = '0;
                    state_next      = COLLECT;
                end
            end

            COLLECT: begin
                // A byte arriving on the expiry cycle wins over the timeout.
                if (rx_done_tick) begin
                    shift_buf_next  = shifted;
                    byte_count_next = byte_count + 2'd1;
                    timer_next      = '0;
                    if (byte_count == 2'd3) begin
                        data_next = shifted;
                        if (crypt_busy) begin
                            state_next = HOLD;
                        end else begin
                            ready_next = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end else if (timer == TIMER_LAST) begin
                    state_next      = IDLE;
                    byte_count_next = 2'd0;
                    timer_next      = '0;
                    timeout_next    = 1'b1;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end

            HOLD: begin
                if (!crypt_busy) begin
                    ready_next = 1'b1;
                    if (rx_done_tick) begin
                        shift_buf_next  = shifted;
                        byte_count_next = byte_count + 2'd1;
                        timer_next      = '0;
                        state_next      = COLLECT;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (rx_done_tick) begin
                    overrun_next = 1'b1;
                end
            end

            default: begin
                state_next      = IDLE;
                byte_count_next = 2'd0;
                timer_next      = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            byte_count   <= 2'd0;
            shift_buf    <= 32'd0;
            timer        <= '0;
            data_out     <= 32'd0;
            word_ready   <= 1'b0;
            overrun_tick <= 1'b0;
            timeout_tick <= 1'b0;
        end else begin
            state        <= state_next;
            byte_count   <= byte_count_next;
            shift_buf    <= shift_buf_next;
            timer        <= timer_next;
            data_out     <= data_next;
            word_ready   <= ready_next;
            overrun_tick <= overrun_next;
            timeout_tick <= timeout_next;
        end
    end

endmodule

// File: tb/tb_encrypter_in.sv
// Bench for encrypter_in: directed scenarios plus random traffic, compared every cycle
// against a byte-queue model of the word assembler.
module tb_encrypter_in;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_done_tick;
    logic [7:0]  rx_data;
    logic        crypt_busy;
    logic        word_ready;
    logic [31:0] data_out;
    logic        receiving;
    logic        overrun_tick;
    logic        timeout_tick;

    int checks = 0;
    int errors = 0;
    int ready_count = 0;

    // Model: bytes of the word in progress, a held-word flag and the idle run length.
    logic [7:0]  partial[$];
    bit          held = 1'b0;
    int          idle_run = 0;
    logic        m_ready = 1'b0;
    logic        m_ovr = 1'b0;
    logic        m_to = 1'b0;
    logic        m_recv = 1'b0;
    logic [31:0] m_data = 32'd0;

    encrypter_in #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .crypt_busy   (crypt_busy),
        .word_ready   (word_ready),
        .data_out     (data_out),
        .receiving    (receiving),
        .overrun_tick (overrun_tick),
        .timeout_tick (timeout_tick)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task model_step;
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        m_to    = 1'b0;
        if (rst) begin
            partial.delete();
            held     = 1'b0;
            idle_run = 0;
            m_data   = 32'd0;
        end else if (held) begin
            if (!crypt_busy) begin
                m_ready = 1'b1;
                held    = 1'b0;
                if (rx_done_tick) begin
                    partial.push_back(rx_data);
                    idle_run = 0;
                end
            end else if (rx_done_tick) begin
                m_ovr = 1'b1;
            end
        end else if (rx_done_tick) begin
            partial.push_back(rx_data);
            idle_run = 0;
            if (partial.size() == 4) begin
                m_data = {partial[0], partial[1], partial[2], partial[3]};
                partial.delete();
                if (crypt_busy) held = 1'b1;
                else            m_ready = 1'b1;
            end
        end else if (partial.size() != 0) begin
            idle_run++;
            if (idle_run == T - 1) begin
                partial.delete();
                idle_run = 0;
                m_to     = 1'b1;
            end
        end
        m_recv = held || (partial.size() != 0);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        check_output("word_ready", {31'd0, word_ready}, {31'd0, m_ready});
        check_output("data_out", data_out, m_data);
        check_output("receiving", {31'd0, receiving}, {31'd0, m_recv});
        check_output("overrun_tick", {31'd0, overrun_tick}, {31'd0, m_ovr});
        check_output("timeout_tick", {31'd0, timeout_tick}, {31'd0, m_to});
        if (word_ready === 1'b1) ready_count++;
    end

    // Drive one cycle of inputs; returns just after the edge that sampled them.
    task apply_stimulus(input logic tick, input logic [7:0] data, input logic busy);
        rx_done_tick = tick;
        rx_data      = data;
        crypt_busy   = busy;
        @(posedge clk);
        #1;
    endtask

    task send_word(input logic [31:0] word, input logic busy, input int gap);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, word[31 - 8 * i -: 8], busy);
            if (i < 3) begin
                for (int g = 0; g < gap; g++) apply_stimulus(1'b0, 8'h00, busy);
            end
        end
    endtask

    initial begin
        int rc;
        int tick_pct;
        logic busy_r;

        rst          = 1'b1;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        crypt_busy   = 1'b0;
        repeat (2) apply_stimulus(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        check_output("reset_data", data_out, 32'd0);
        check_output("reset_receiving", {31'd0, receiving}, 32'd0);

        send_word(32'hDEADBEEF, 1'b0, 2);
        check_output("word1_ready", {31'd0, word_ready}, 32'd1);
        check_output("word1_data", data_out, 32'hDEADBEEF);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("word1_ready_drop", {31'd0, word_ready}, 32'd0);
        check_output("word1_recv_drop", {31'd0, receiving}, 32'd0);

        rc = ready_count;
        send_word(32'hDEADBEEF, 1'b0, 0);
        check_output("b2b_ready", {31'd0, word_ready}, 32'd1);
        check_output("b2b_data", data_out, 32'hDEADBEEF);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("b2b_pulse_count", ready_count, rc + 1);

        send_word(32'h01020304, 1'b1, 0);
        check_output("hold_ready", {31'd0, word_ready}, 32'd0);
        check_output("hold_receiving", {31'd0, receiving}, 32'd1);
        rc = ready_count;
        repeat (10) apply_stimulus(1'b0, 8'h00, 1'b1);
        apply_stimulus(1'b1, 8'h55, 1'b1);
        check_output("overrun_pulse", {31'd0, overrun_tick}, 32'd1);
        check_output("overrun_data", data_out, 32'h01020304);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("overrun_single", {31'd0, overrun_tick}, 32'd0);
        check_output("hold_no_ready", ready_count, rc);
        apply_stimulus(1'b1, 8'h11, 1'b0);
        check_output("release_ready", {31'd0, word_ready}, 32'd1);
        check_output("release_data", data_out, 32'h01020304);
        check_output("release_receiving", {31'd0, receiving}, 32'd1);
        apply_stimulus(1'b1, 8'h22, 1'b0);
        apply_stimulus(1'b1, 8'h33, 1'b0);
        apply_stimulus(1'b1, 8'h44, 1'b0);
        check_output("next_word_ready", {31'd0, word_ready}, 32'd1);
        check_output("next_word_data", data_out, 32'h11223344);

        apply_stimulus(1'b1, 8'hAA, 1'b0);
        apply_stimulus(1'b1, 8'hBB, 1'b0);
        repeat (T - 2) apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("timeout_early", {31'd0, timeout_tick}, 32'd0);
        check_output("timeout_recv_early", {31'd0, receiving}, 32'd1);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("timeout_pulse", {31'd0, timeout_tick}, 32'd1);
        check_output("timeout_receiving", {31'd0, receiving}, 32'd0);
        check_output("timeout_no_ready", {31'd0, word_ready}, 32'd0);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("timeout_single", {31'd0, timeout_tick}, 32'd0);
        send_word(32'h01020304, 1'b0, 1);
        check_output("after_timeout_data", data_out, 32'h01020304);

        apply_stimulus(1'b1, 8'hAA, 1'b0);
        apply_stimulus(1'b1, 8'hBB, 1'b0);
        repeat (T - 2) apply_stimulus(1'b0, 8'h00, 1'b0);
        apply_stimulus(1'b1, 8'hCC, 1'b0);
        check_output("edge_no_timeout", {31'd0, timeout_tick}, 32'd0);
        check_output("edge_receiving", {31'd0, receiving}, 32'd1);
        apply_stimulus(1'b1, 8'hDD, 1'b0);
        check_output("edge_ready", {31'd0, word_ready}, 32'd1);
        check_output("edge_data", data_out, 32'hAABBCCDD);

        apply_stimulus(1'b1, 8'h12, 1'b0);
        apply_stimulus(1'b1, 8'h34, 1'b0);
        rst = 1'b1;
        apply_stimulus(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        check_output("rst_mid_data", data_out, 32'd0);
        check_output("rst_mid_receiving", {31'd0, receiving}, 32'd0);
        send_word(32'hCAFEF00D, 1'b0, 0);
        check_output("rst_mid_word", data_out, 32'hCAFEF00D);

        send_word(32'h0BADC0DE, 1'b1, 0);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        rst = 1'b1;
        apply_stimulus(1'b0, 8'h00, 1'b1);
        rst = 1'b0;
        check_output("rst_hold_data", data_out, 32'd0);
        check_output("rst_hold_receiving", {31'd0, receiving}, 32'd0);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("rst_hold_lost", {31'd0, word_ready}, 32'd0);
        send_word(32'h13579BDF, 1'b0, 1);
        check_output("rst_hold_word", data_out, 32'h13579BDF);

        tick_pct = 40;
        busy_r   = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       tick_pct = 5;
                    1:       tick_pct = 40;
                    default: tick_pct = 90;
                endcase
            end
            if ($urandom_range(0, 9) == 0) busy_r = ~busy_r;
            rst = ($urandom_range(0, 799) == 0);
            apply_stimulus($urandom_range(0, 99) < tick_pct, 8'($urandom), busy_r);
        end
        rst = 1'b0;
        repeat (T + 4) apply_stimulus(1'b0, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
